// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_fifo
// Description : Show-ahead output FIFO behind the FIR stage. It provides
//               registered PAUSE back-pressure and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_fifo #(
    parameter int NB       = 8,
    parameter int DEPTH    = 16,
    parameter int PAUSE_TH = 12
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic [NB-1:0]            DIN,
    input  logic                     VIN,
    input  logic                     READY,
    output logic [NB-1:0]            DOUT,
    output logic                     VOUT,
    output logic                     PAUSE,
    output logic                     OVF,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int                 c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_DEPTH    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]      c_PAUSE_TH = (c_AW+1)'(PAUSE_TH);
    localparam logic [c_AW:0]      c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);

    logic [NB-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_pause;
    logic            r_ovf;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_AW:0]   w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    assign w_pop   = !w_empty && READY;
    assign w_push  = VIN && (!w_full || w_pop);
    assign w_drop  = VIN && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage holds no reset; stale entries are never visible because DOUT is gated.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pause  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_pause <= (w_count_nxt >= c_PAUSE_TH);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign VOUT  = !w_empty;
    assign DOUT  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign PAUSE = r_pause;
    assign OVF   = r_ovf;
    assign COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_out_fifo
// Description : Self-checking bench for fir_out_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_out_fifo;

    localparam int c_NB       = 8;
    localparam int c_DEPTH    = 16;
    localparam int c_PAUSE_TH = 12;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic [c_NB-1:0]   DIN;
    logic              VIN;
    logic              READY;
    logic [c_NB-1:0]   DOUT;
    logic              VOUT;
    logic              PAUSE;
    logic              OVF;
    logic [4:0]        COUNT;

    fir_out_fifo #(
        .NB       (c_NB),
        .DEPTH    (c_DEPTH),
        .PAUSE_TH (c_PAUSE_TH)
    ) u_dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .DIN   (DIN),
        .VIN   (VIN),
        .READY (READY),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .PAUSE (PAUSE),
        .OVF   (OVF),
        .COUNT (COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_pause;

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       ready;
        logic       exp_vout;
        logic [7:0] exp_dout;
        logic [4:0] exp_count;
        logic       exp_pause;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input logic v, input logic [7:0] d, input logic r);
        bit pop;
        bit full;
        bit push;
        pop  = (mq.size() != 0) && r;
        full = (mq.size() == c_DEPTH);
        push = v && (!full || pop);
        if (v && full && !pop) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
        m_pause = (mq.size() >= c_PAUSE_TH);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".vout"},  int'(VOUT),  (mq.size() != 0) ? 1 : 0);
        chk({tag, ".dout"},  int'(DOUT),  (mq.size() != 0) ? int'(mq[0]) : 0);
        chk({tag, ".count"}, int'(COUNT), mq.size());
        chk({tag, ".pause"}, int'(PAUSE), int'(m_pause));
        chk({tag, ".ovf"},   int'(OVF),   int'(m_ovf));
    endtask

    // Drive inputs, take one rising edge, update the model, settle 1 time unit.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        VIN   = v;
        DIN   = d;
        READY = r;
        @(posedge CLK);
        model_edge(v, d, r);
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        m_pause = 1'b0;
        VIN = 1'b0; READY = 1'b0; DIN = '0;
        #1;
        check_model("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        RST_n = 1'b0; VIN = 1'b0; READY = 1'b0; DIN = '0;

        tbl[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

        do_reset();

        // Single sample, READY-on-empty, and show-ahead streaming vectors.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].vin, tbl[i].din, tbl[i].ready);
            chk($sformatf("tbl%0d.vout", i),  int'(VOUT),  int'(tbl[i].exp_vout));
            chk($sformatf("tbl%0d.dout", i),  int'(DOUT),  int'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d.count", i), int'(COUNT), int'(tbl[i].exp_count));
            chk($sformatf("tbl%0d.pause", i), int'(PAUSE), int'(tbl[i].exp_pause));
            chk($sformatf("tbl%0d.ovf", i),   int'(OVF),   int'(tbl[i].exp_ovf));
        end

        // Fill, overflow, drain.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check_model("fill");
            if (i == 11) chk("fill.pause11", int'(PAUSE), 0);
            if (i == 12) chk("fill.pause12", int'(PAUSE), 1);
        end
        chk("fill.count16", int'(COUNT), 16);
        chk("fill.ovf16", int'(OVF), 0);
        step(1'b1, 8'h11, 1'b0);
        chk("ovf.set", int'(OVF), 1);
        chk("ovf.count", int'(COUNT), 16);
        for (int i = 1; i <= 16; i++) begin
            chk("drain.order", int'(DOUT), i);
            step(1'b0, 8'h00, 1'b1);
            check_model("drain");
        end
        chk("drain.empty", int'(VOUT), 0);
        chk("ovf.sticky", int'(OVF), 1);

        // Full plus simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        chk("fullpp.count", int'(COUNT), 16);
        chk("fullpp.ovf", int'(OVF), 0);
        chk("fullpp.head", int'(DOUT), 2);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fullpp.last", int'(DOUT), 8'h77);
            step(1'b0, 8'h00, 1'b1);
            check_model("fullpp");
        end

        // Streaming with zero latency.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom);
            step(1'b1, d, 1'b1);
            chk("stream.dout", int'(DOUT), int'(d));
            chk("stream.cnt_le1", (COUNT <= 5'd1) ? 1 : 0, 1);
            chk("stream.pause", int'(PAUSE), 0);
        end

        // PAUSE release and re-assertion without hysteresis.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 8'h40), 1'b0);
        chk("prel.pause12", int'(PAUSE), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("prel.released", int'(PAUSE), 0);
        chk("prel.count11", int'(COUNT), 11);
        step(1'b1, 8'h99, 1'b0);
        chk("prel.reassert", int'(PAUSE), 1);

        // Asynchronous reset mid-operation, then first push after release.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        chk("areset.pre_count", int'(COUNT), 9);
        chk("areset.pre_ovf", int'(OVF), 1);
        #2;
        RST_n = 1'b0;
        #1;
        chk("areset.count", int'(COUNT), 0);
        chk("areset.vout", int'(VOUT), 0);
        chk("areset.dout", int'(DOUT), 0);
        chk("areset.pause", int'(PAUSE), 0);
        chk("areset.ovf", int'(OVF), 0);
        mq.delete();
        m_ovf = 1'b0;
        m_pause = 1'b0;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        step(1'b1, 8'h33, 1'b0);
        chk("areset.first_dout", int'(DOUT), 8'h33);
        chk("areset.first_count", int'(COUNT), 1);

        // Randomized traffic in phases of varying push/pop pressure.
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            int pv;
            int pr;
            pv = 30 + 10 * ph;
            pr = 90 - 10 * ph;
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(99) < pv) ? 1'b1 : 1'b0, 8'($urandom),
                     ($urandom_range(99) < pr) ? 1'b1 : 1'b0);
                check_model("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_out_fifo.md
FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 The module SHALL take parameter NB, default 8: sample width in bits, equal to the filter DOUT width.
REQ-002 The module SHALL take parameter DEPTH, default 16: FIFO entries, power of two, minimum 4.
REQ-003 The module SHALL take parameter PAUSE_TH, default 12: occupancy at which PAUSE asserts, 1 <= PAUSE_TH < DEPTH.
REQ-004 The module SHALL have port CLK  in  1: single clock, all state updates on the rising edge.
REQ-005 The module SHALL have port RST_n  in  1: asynchronous, active-low reset.
REQ-006 The module SHALL have port DIN  in  NB: filtered sample from the FIR stage output.
REQ-007 The module SHALL have port VIN  in  1: DIN valid, driven by the FIR stage VOUT.
REQ-008 The module SHALL have port READY  in  1: downstream consumer accepts the head sample this cycle.
REQ-009 The module SHALL have port DOUT  out  NB: head-of-FIFO sample.
REQ-010 The module SHALL have port VOUT  out  1: DOUT valid (FIFO not empty).
REQ-011 The module SHALL have port PAUSE  out  1: back-pressure to the sample source feeding the FIR stage.
REQ-012 The module SHALL have port OVF  out  1: sticky overflow flag (a sample was dropped).
REQ-013 The module SHALL have port COUNT  out  log2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-014 The module SHALL store the sample on an edge (push) when VIN=1 and the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-015 The module SHALL remove the head (pop) on an edge where VOUT=1 and READY=1; READY while VOUT=0 SHALL have no effect.
REQ-016 Show-ahead: a sample pushed at edge k SHALL appear on DOUT with VOUT=1 from edge k onward if the FIFO was empty, with no extra latency cycle.
REQ-017 VOUT SHALL equal (COUNT != 0); DOUT SHALL be all zeros whenever VOUT=0.
REQ-018 Sample order SHALL be strictly FIFO; DOUT SHALL be bit-identical to DIN as written.
REQ-019 On a simultaneous push and pop, COUNT SHALL stay unchanged and both pointers SHALL advance.
REQ-020 Write and read pointers SHALL wrap modulo DEPTH; full is COUNT=DEPTH, empty is COUNT=0.
REQ-021 When VIN=1 with the FIFO full and no pop, the sample SHALL be dropped, the contents left unchanged, and OVF set to 1 on that edge.
REQ-022 OVF SHALL remain 1 until reset.
REQ-023 PAUSE SHALL be a registered output equal to (COUNT after the edge >= PAUSE_TH).
REQ-024 PAUSE SHALL deassert on the first edge where the updated COUNT < PAUSE_TH; no hysteresis.
REQ-025 The DEPTH-PAUSE_TH headroom SHALL absorb samples still in flight in the FIR pipeline after PAUSE.

Reset
REQ-026 RST_n=0 SHALL immediately force pointers=0, COUNT=0, VOUT=0, DOUT=0, PAUSE=0, and OVF=0, independent of CLK.
REQ-027 Storage contents SHALL NOT require reset.
REQ-028 A reset asserted mid-operation SHALL discard all stored samples.
REQ-029 The first push SHALL be accepted on the first rising edge after RST_n deasserts.

Verification
REQ-030 Single sample: push DIN=0x5A with READY=0 -> VOUT=1, DOUT=0x5A, COUNT=1 after that edge; READY=1 one cycle -> VOUT=0, DOUT=0x00, COUNT=0.
REQ-031 Fill: 16 pushes of 0x01..0x10 with READY=0 -> PAUSE=1 after the 12th push, COUNT=16, OVF=0; a 17th push of 0x11 -> OVF=1, COUNT=16, 0x11 lost; draining yields 0x01..0x10 in order.
REQ-032 Full plus simultaneous push/pop: FIFO full, VIN=1 DIN=0x77, READY=1 -> COUNT stays 16, OVF=0, head advances, 0x77 emerges last.
REQ-033 Streaming: VIN=1 and READY=1 every cycle for 100 samples -> COUNT stays at most 1, PAUSE=0, output equals input delayed 0 cycles after first push.
REQ-034 PAUSE release: COUNT=12 with PAUSE=1, pop one with no push -> PAUSE=0 after that edge; push one -> PAUSE=1 again.
REQ-035 Async reset: COUNT=9, OVF=1, drop RST_n between edges -> all outputs 0 immediately; after release, push 0x33 -> DOUT=0x33, COUNT=1.
